// File: rtl/alu_sequencer.sv
// ALU front-panel sequencer: walks the operator through loading operands and
// an opcode, fires the ALU, then shows the result or flags an error.
module alu_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned MAX_OP  = 11,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Btn_next,
  input  logic              Btn_back,
  input  logic [DATA_W-1:0] Sw,
  input  logic [DATA_W-1:0] Alu_result,
  input  logic              Alu_done,
  output logic [DATA_W-1:0] Op_a,
  output logic [DATA_W-1:0] Op_b,
  output logic [OP_W-1:0]   Opcode,
  output logic              Alu_start,
  output logic [DATA_W-1:0] Result_q,
  output logic              Done,
  output logic              Error,
  output logic [2:0]        State_code
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [OP_W-1:0] OpMax   = OP_W'(MAX_OP);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StLoadOp = 3'd3,
    StExec  = 3'd4,
    StWait  = 3'd5,
    StShow  = 3'd6,
    StErr   = 3'd7
  } state_e;

  state_e          state_q;
  logic            next_prev_q;
  logic            back_prev_q;
  logic [CntW-1:0] wait_cnt_q;

  logic next_rise;
  logic back_rise;
  logic next_press;
  logic back_press;

  // Rising-edge press detection; simultaneous presses cancel each other out.
  always_comb begin
    next_rise  = Btn_next & ~next_prev_q;
    back_rise  = Btn_back & ~back_prev_q;
    next_press = next_rise & ~back_rise;
    back_press = back_rise & ~next_rise;
  end

  // Previous-level registers reset high so a button held through reset is not a press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      next_prev_q <= 1'b1;
      back_prev_q <= 1'b1;
    end else begin
      next_prev_q <= Btn_next;
      back_prev_q <= Btn_back;
    end
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      Op_a       <= '0;
      Op_b       <= '0;
      Opcode     <= '0;
      Alu_start  <= 1'b0;
      Result_q   <= '0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      Alu_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (next_press) state_q <= StLoadA;
        end
        StLoadA: begin
          if (next_press) begin
            Op_a    <= Sw;
            state_q <= StLoadB;
          end
        end
        StLoadB: begin
          if (next_press) begin
            Op_b    <= Sw;
            state_q <= StLoadOp;
          end else if (back_press) begin
            state_q <= StLoadA;
          end
        end
        StLoadOp: begin
          if (next_press) begin
            Opcode <= Sw[OP_W-1:0];
            if (Sw[OP_W-1:0] > OpMax) begin
              Error   <= 1'b1;
              state_q <= StErr;
            end else begin
              // Start is high exactly while the FSM sits in EXEC.
              Alu_start <= 1'b1;
              state_q   <= StExec;
            end
          end else if (back_press) begin
            state_q <= StLoadB;
          end
        end
        StExec: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          // Done takes priority over a timeout landing on the same cycle.
          if (Alu_done) begin
            Result_q <= Alu_result;
            Done     <= 1'b1;
            state_q  <= StShow;
          end else if (wait_cnt_q == CntLast) begin
            Error   <= 1'b1;
            state_q <= StErr;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntOne;
          end
        end
        StShow: begin
          if (next_press) begin
            Done    <= 1'b0;
            state_q <= StLoadA;
          end
        end
        StErr: begin
          if (next_press) begin
            Error    <= 1'b0;
            Op_a     <= '0;
            Op_b     <= '0;
            Opcode   <= '0;
            Result_q <= '0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign State_code = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a result scoreboard.
module tb_alu_sequencer;

  localparam int TIMEOUT = 16;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Btn_next = 1'b0;
  logic       Btn_back = 1'b0;
  logic [7:0] Sw = 8'h00;
  logic [7:0] Alu_result = 8'h00;
  logic       Alu_done = 1'b0;
  logic [7:0] Op_a;
  logic [7:0] Op_b;
  logic [3:0] Opcode;
  logic       Alu_start;
  logic [7:0] Result_q;
  logic       Done;
  logic       Error;
  logic [2:0] State_code;

  alu_sequencer #(
    .DATA_W (8),
    .OP_W   (4),
    .MAX_OP (11),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Btn_next  (Btn_next),
    .Btn_back  (Btn_back),
    .Sw        (Sw),
    .Alu_result(Alu_result),
    .Alu_done  (Alu_done),
    .Op_a      (Op_a),
    .Op_b      (Op_b),
    .Opcode    (Opcode),
    .Alu_start (Alu_start),
    .Result_q  (Result_q),
    .Done      (Done),
    .Error     (Error),
    .State_code(State_code)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   start_cnt = 0;

  // Count start pulses mid-cycle, away from the active edge.
  always @(negedge Clk) if (Alu_start === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic press_next();
    Btn_next = 1'b1;
    step();
    Btn_next = 1'b0;
    step();
  endtask

  task automatic press_back();
    Btn_back = 1'b1;
    step();
    Btn_back = 1'b0;
    step();
  endtask

  // From LOAD_A: load both operands and opcode; ends one cycle into WAIT.
  task automatic go_exec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    Sw = a;
    press_next();
    Sw = b;
    press_next();
    Sw = {4'h0, op};
    press_next();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 8; i++) begin
      if (Done === 1'b1) break;
      step();
    end
    check("done_seen", {31'd0, Done}, 32'd1);
  endtask

  task automatic show_check();
    exp_t e;
    check("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("show_result", {24'd0, Result_q}, {24'd0, e.res});
      check("show_op_a", {24'd0, Op_a}, {24'd0, e.a});
      check("show_op_b", {24'd0, Op_b}, {24'd0, e.b});
      check("show_opcode", {28'd0, Opcode}, {28'd0, e.op});
      check("show_state", {29'd0, State_code}, 32'd6);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base;
    logic stay_ok;

    // Reset state
    step();
    step();
    check("rst_state", {29'd0, State_code}, 32'd0);
    check("rst_op_a", {24'd0, Op_a}, 32'd0);
    check("rst_op_b", {24'd0, Op_b}, 32'd0);
    check("rst_opcode", {28'd0, Opcode}, 32'd0);
    check("rst_result", {24'd0, Result_q}, 32'd0);
    check("rst_flags", {29'd0, Alu_start, Done, Error}, 32'd0);
    Reset = 1'b0;
    step();

    // Nominal transaction
    sb.push_back('{a: 8'h12, b: 8'h34, op: 4'h3, res: 8'h46});
    base = start_cnt;
    press_next();
    check("idle_to_a", {29'd0, State_code}, 32'd1);
    Sw = 8'h12;
    press_next();
    check("cap_a", {24'd0, Op_a}, 32'h12);
    check("a_to_b", {29'd0, State_code}, 32'd2);
    Sw = 8'h34;
    press_next();
    check("cap_b", {24'd0, Op_b}, 32'h34);
    check("b_to_op", {29'd0, State_code}, 32'd3);
    Sw = 8'h03;
    press_next();
    check("in_wait", {29'd0, State_code}, 32'd5);
    check("cap_op", {28'd0, Opcode}, 32'd3);
    step();
    step();
    Alu_result = 8'h46;
    Alu_done = 1'b1;
    step();
    Alu_done = 1'b0;
    Alu_result = 8'h00;
    wait_done();
    show_check();
    check("one_start", start_cnt - base, 32'd1);

    // Held button and simultaneous presses
    press_next();
    check("show_to_a", {29'd0, State_code}, 32'd1);
    check("done_clr", {31'd0, Done}, 32'd0);
    check("a_retained", {24'd0, Op_a}, 32'h12);
    Sw = 8'h55;
    Btn_next = 1'b1;
    step();
    Sw = 8'h66;
    repeat (9) step();
    check("hold_one_cap", {24'd0, Op_a}, 32'h55);
    check("hold_state", {29'd0, State_code}, 32'd2);
    check("hold_b_kept", {24'd0, Op_b}, 32'h34);
    Btn_next = 1'b0;
    step();
    Btn_next = 1'b1;
    Btn_back = 1'b1;
    step();
    Btn_next = 1'b0;
    Btn_back = 1'b0;
    step();
    check("both_ignored", {29'd0, State_code}, 32'd2);
    press_back();
    check("back_to_a", {29'd0, State_code}, 32'd1);
    check("back_keep_a", {24'd0, Op_a}, 32'h55);
    Sw = 8'h0A;
    press_next();
    Sw = 8'h0B;
    press_next();
    press_back();
    check("op_back_to_b", {29'd0, State_code}, 32'd2);
    Sw = 8'h0C;
    press_next();
    check("reload_b", {24'd0, Op_b}, 32'h0C);

    // Illegal opcode
    base = start_cnt;
    Sw = 8'h0F;
    press_next();
    check("bad_op_state", {29'd0, State_code}, 32'd7);
    check("bad_op_error", {31'd0, Error}, 32'd1);
    check("bad_op_nostart", start_cnt - base, 32'd0);
    press_back();
    check("err_back_ign", {29'd0, State_code}, 32'd7);
    press_next();
    check("err_to_idle", {29'd0, State_code}, 32'd0);
    check("err_clr", {Op_a, Op_b, Opcode, Result_q, 3'd0, Error}, 32'd0);

    // Timeout without done
    press_next();
    go_exec(8'h01, 8'h02, 4'h5);
    stay_ok = 1'b1;
    repeat (TIMEOUT - 1) begin
      step();
      if (State_code !== 3'd5) stay_ok = 1'b0;
    end
    check("wait_held", {31'd0, stay_ok}, 32'd1);
    step();
    check("timeout_err", {29'd0, State_code}, 32'd7);
    check("timeout_flag", {31'd0, Error}, 32'd1);
    press_next();

    // Done on the timeout cycle wins; highest legal opcode
    sb.push_back('{a: 8'h21, b: 8'h43, op: 4'hB, res: 8'h99});
    press_next();
    go_exec(8'h21, 8'h43, 4'hB);
    repeat (TIMEOUT - 1) step();
    Alu_result = 8'h99;
    Alu_done = 1'b1;
    step();
    Alu_done = 1'b0;
    show_check();
    Alu_result = 8'h77;
    Alu_done = 1'b1;
    step();
    Alu_done = 1'b0;
    step();
    check("late_done_ign", {24'd0, Result_q}, 32'h99);

    // Button held across reset release
    press_next();
    Btn_next = 1'b1;
    Reset = 1'b1;
    #1;
    check("async_rst", {29'd0, State_code}, 32'd0);
    step();
    Reset = 1'b0;
    repeat (3) step();
    check("held_no_press", {29'd0, State_code}, 32'd0);
    Btn_next = 1'b0;
    step();
    press_next();
    check("repress", {29'd0, State_code}, 32'd1);

    // Reset mid-WAIT aborts
    go_exec(8'h31, 8'h32, 4'h1);
    step();
    Reset = 1'b1;
    #1;
    check("wait_rst_state", {29'd0, State_code}, 32'd0);
    step();
    Reset = 1'b0;
    Alu_result = 8'hAA;
    Alu_done = 1'b1;
    step();
    Alu_done = 1'b0;
    step();
    check("wait_rst_res", {24'd0, Result_q}, 32'd0);
    check("wait_rst_idle", {29'd0, State_code, Done}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
